mema_loader: RTL and testbench
==============================

Name: mema_loader

Overview:
- Upstream feeder for the A-operand skew memory of the systolic matrix multiplier.
- Accepts A elements as a serial valid/ready stream in row-major order and packs each row of DIM elements into one wide row word.
- Writes each row word into the skew memory with a write strobe and row index, then asserts the skew memory's shift enable for a fixed number of cycles so the array sees the full skewed matrix.
- Pulses done when the stream-out phase ends and then accepts the next matrix.

Parameters:
- BITS_AB, 8: signed element width.
- DIM, 8: matrix dimension, i.e. rows per matrix and elements per row.
- STREAM_LEN, 3*DIM-2: number of mem_en cycles per matrix (skew-in plus array drain).

Ports:
- clk  in  1  clock; the block has one clock, all logic on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  upstream element valid.
- in_ready  out  1  loader can accept an element.
- in_data  in  BITS_AB signed  element; row-major, index r*DIM+c.
- in_last  in  1  end-of-matrix marker; used only under LOADER_PARTIAL_ROW_EN, ignored otherwise.
- mem_wren  out  1  row write strobe to the skew memory.
- mem_arow  out  $clog2(DIM)  row index being written.
- mem_ain  out  BITS_AB signed x DIM (unpacked array)  row word; mem_ain[c] is column c.
- mem_en  out  1  shift enable to the skew memory.
- busy  out  1  high in every state except LOAD with no element yet accepted for the current matrix.
- done  out  1  one-cycle pulse at the end of a matrix.

Behaviour:
- Reset values: in_ready=0 during rst, 1 on the first cycle after; mem_wren=0, mem_en=0, mem_arow=0, mem_ain all 0, busy=0, done=0. Column, row and stream counters clear to 0 and the state is LOAD.
- Reset mid-operation: the partial row is discarded and no further strobes are issued. Skew memory contents are not cleared by this block.
- States: LOAD, STREAM, DONE.
- LOAD: in_ready=1 and an element is accepted when in_valid and in_ready are both high.
  - An accepted element goes to packer column col; col then increments.
  - On acceptance of column DIM-1, the packed row (including that element) is registered into mem_ain and mem_arow=row. mem_wren=1 on the next cycle, for exactly one cycle, and col returns to 0.
  - Acceptance continues without a stall during that write cycle.
  - When the accepted element is column DIM-1 of row DIM-1, in_ready drops the next cycle. The state goes to STREAM on the cycle after the final mem_wren.
- STREAM: mem_en=1 for exactly STREAM_LEN consecutive cycles and in_ready=0. Then the state goes to DONE.
- DONE: done=1 for one cycle and in_ready=0. The next state is LOAD.
- mem_wren and mem_en are never high in the same cycle (the skew memory treats them as exclusive).
- mem_ain and mem_arow hold their value between writes. No downstream backpressure exists.
- Gaps in in_valid only stretch LOAD; the packed data is unaffected.
- in_valid during STREAM or DONE is not accepted, and upstream must hold in_data. There is no overflow path.

Optional Feature:
- Macro LOADER_PARTIAL_ROW_EN.
- Defined: in_last on an accepted element ends the matrix early.
  - The remaining columns of the current row are zero-padded and that row is written on the next cycle.
  - Each remaining row up to DIM-1 is then written as all zeros, one per cycle with consecutive mem_wren and incrementing mem_arow.
  - Then STREAM.
  - in_last on column DIM-1 of row DIM-1 behaves exactly like a full matrix.
  - in_ready=0 from the in_last acceptance until LOAD is re-entered.
- Undefined: in_last is ignored and exactly DIM*DIM elements form each matrix.

Decomposition:
- Package sa_pkg holds:
  - the loader state enum (LOAD, STREAM, DONE);
  - a function returning the default STREAM_LEN for a given DIM;
  - the shared BITS_AB and DIM defaults used by the skew memories and the array.
- Sub-module row_packer: column counter plus DIM-wide packing register, zero-padding input and row-complete output. It is instantiated once.

Test Plan:
- DIM=4, BITS_AB=8. Hold rst high 2 cycles -> all outputs 0 during reset; after release in_ready=1, busy=0, mem_wren=0, mem_en=0.
- Send elements 1..16 back-to-back -> mem_wren pulses one cycle after elements 4, 8, 12, 16 with mem_arow 0,1,2,3. Row 0 mem_ain = {1,2,3,4}, with mem_ain[0]=1. Then mem_en is high for exactly 10 cycles, done pulses next, and in_ready returns high.
- Same data with in_valid high every other cycle -> identical row words and arow sequence, only later. mem_wren and mem_en are never coincident.
- Assert rst after 6 elements, then send 101..116 -> no write from the aborted matrix. First write is arow=0, mem_ain={101,102,103,104}.
- Hold in_valid high with data 200 throughout STREAM/DONE -> in_ready=0 and nothing is accepted. 200 is accepted on the first LOAD cycle as row 0, column 0.
- LOADER_PARTIAL_ROW_EN, elements 1..6 with in_last on 6 -> writes row 0 = {1,2,3,4}, row 1 = {5,6,0,0}, rows 2 and 3 all zero on consecutive cycles. Then mem_en is high for 10 cycles and done pulses.

Source files
------------

// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared types and defaults for the systolic array operand path
//
// Contents:
//   BITS_AB_DEFAULT  default signed element width shared by the skew memories and the array
//   DIM_DEFAULT      default matrix dimension shared by the skew memories and the array
//   loader_state_t   mema_loader FSM states (LOAD, STREAM, DONE)
//   stream_len()     default number of skew-memory shift cycles for a given DIM
package sa_pkg;

  localparam int BITS_AB_DEFAULT = 8;
  localparam int DIM_DEFAULT     = 8;

  typedef enum logic [1:0] {
    LOAD,
    STREAM,
    DONE
  } loader_state_t;

  // Skew-in takes 2*DIM-1 cycles and the array needs DIM-1 more to drain.
  function automatic int stream_len(input int dim);
    return 3 * dim - 2;
  endfunction

endpackage

// File: rtl/mema_loader_if.sv
// rtl/mema_loader_if.sv - element stream and skew-memory write bus of mema_loader
//
// Signals:
//   in_valid, in_ready, in_data, in_last   upstream element stream (row-major A elements)
//   mem_wren, mem_arow, mem_ain, mem_en    skew memory row write and shift enable
//   busy, done                             loader status
// Modports:
//   master  upstream / test side: drives the element stream, observes everything else
//   slave   loader side: consumes the element stream, drives the memory bus and status
interface mema_loader_if
  import sa_pkg::*;
#(
  parameter int BITS_AB = BITS_AB_DEFAULT,
  parameter int DIM     = DIM_DEFAULT
);

  localparam int AW = (DIM > 1) ? $clog2(DIM) : 1;

  logic                      in_valid;
  logic                      in_ready;
  logic signed [BITS_AB-1:0] in_data;
  logic                      in_last;

  logic                      mem_wren;
  logic [AW-1:0]             mem_arow;
  logic signed [BITS_AB-1:0] mem_ain [DIM];
  logic                      mem_en;

  logic                      busy;
  logic                      done;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, mem_wren, mem_arow, mem_ain, mem_en, busy, done
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, mem_wren, mem_arow, mem_ain, mem_en, busy, done
  );

endinterface

// File: rtl/row_packer.sv
// rtl/row_packer.sv - column counter and packing register that assembles one row word
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   push          an element is accepted this cycle; it lands in the current column
//   flush         close the row this cycle; columns past the last pushed one read as zero
//   data          element being pushed
//   row_complete  the row closes this cycle (last column pushed, or flush)
//   row_word      packed row including this cycle's element; row_word[c] is column c
module row_packer
  import sa_pkg::*;
#(
  parameter int BITS_AB = BITS_AB_DEFAULT,
  parameter int DIM     = DIM_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      flush,
  input  logic signed [BITS_AB-1:0] data,
  output logic                      row_complete,
  output logic signed [BITS_AB-1:0] row_word [DIM]
);

  localparam int CW = (DIM > 1) ? $clog2(DIM) : 1;

  logic [CW-1:0]             col;
  logic signed [BITS_AB-1:0] pack [DIM];

  assign row_complete = (push && (col == CW'(DIM - 1))) || flush;

  // Stale register contents at or beyond col are masked, so a row closed
  // early is zero-padded without having to clear the register first.
  always_comb begin
    for (int c = 0; c < DIM; c++) begin
      if (CW'(c) < col) begin
        row_word[c] = pack[c];
      end else if ((CW'(c) == col) && push) begin
        row_word[c] = data;
      end else begin
        row_word[c] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      for (int c = 0; c < DIM; c++) begin
        pack[c] <= '0;
      end
    end else begin
      if (push) begin
        pack[col] <= data;
      end
      if (row_complete) begin
        col <= '0;
      end else if (push) begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mema_loader.sv
// rtl/mema_loader.sv - packs a row-major A element stream into rows of the A skew memory
//
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   bus       mema_loader_if.slave: element stream in, skew memory writes / shift enable
//             and busy/done status out
// Build option:
//   LOADER_PARTIAL_ROW_EN  when defined, in_last on an accepted element ends the matrix
//                          early; remaining columns and rows are written as zeros.
module mema_loader
  import sa_pkg::*;
#(
  parameter int BITS_AB    = BITS_AB_DEFAULT,
  parameter int DIM        = DIM_DEFAULT,
  parameter int STREAM_LEN = stream_len(DIM)
) (
  input  logic          clk,
  input  logic          rst,
  mema_loader_if.slave  bus
);

  localparam int AW    = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int CNT_W = $clog2(STREAM_LEN + 1);

  loader_state_t             state;
  logic [AW-1:0]             row;
  logic [CNT_W-1:0]          cnt;
  logic                      zero_fill;  // writing all-zero rows after an early in_last
  logic                      final_wr;   // cycle of the last row write, STREAM follows

  logic                      accept;
  logic                      last_in;
  logic                      flush;
  logic                      row_complete;
  logic signed [BITS_AB-1:0] row_word [DIM];

  assign accept = (state == LOAD) && bus.in_ready && bus.in_valid;

`ifdef LOADER_PARTIAL_ROW_EN
  assign last_in = bus.in_last;
`else
  logic unused_in_last;
  assign unused_in_last = bus.in_last;
  assign last_in        = 1'b0;
`endif

  // zero_fill keeps closing rows each cycle; with push low and col at 0 the
  // packer produces an all-zero word.
  assign flush = (accept && last_in) || zero_fill;

  row_packer #(
    .BITS_AB (BITS_AB),
    .DIM     (DIM)
  ) u_row_packer (
    .clk          (clk),
    .rst          (rst),
    .push         (accept),
    .flush        (flush),
    .data         (bus.in_data),
    .row_complete (row_complete),
    .row_word     (row_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= LOAD;
      row          <= '0;
      cnt          <= '0;
      zero_fill    <= 1'b0;
      final_wr     <= 1'b0;
      bus.in_ready <= 1'b0;
      bus.mem_wren <= 1'b0;
      bus.mem_arow <= '0;
      bus.mem_en   <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      for (int c = 0; c < DIM; c++) begin
        bus.mem_ain[c] <= '0;
      end
    end else begin
      bus.mem_wren <= 1'b0;
      bus.done     <= 1'b0;
      case (state)
        LOAD: begin
          if (accept) begin
            bus.busy <= 1'b1;
          end
          if (final_wr) begin
            final_wr   <= 1'b0;
            state      <= STREAM;
            bus.mem_en <= 1'b1;
            cnt        <= '0;
          end else if (row_complete) begin
            bus.mem_wren <= 1'b1;
            bus.mem_arow <= row;
            for (int c = 0; c < DIM; c++) begin
              bus.mem_ain[c] <= row_word[c];
            end
            if (row == AW'(DIM - 1)) begin
              row          <= '0;
              zero_fill    <= 1'b0;
              final_wr     <= 1'b1;
              bus.in_ready <= 1'b0;
            end else begin
              row <= row + 1'b1;
              if (flush) begin
                zero_fill    <= 1'b1;
                bus.in_ready <= 1'b0;
              end
            end
          end else begin
            bus.in_ready <= 1'b1;
          end
        end

        STREAM: begin
          if (cnt == CNT_W'(STREAM_LEN - 1)) begin
            bus.mem_en <= 1'b0;
            bus.done   <= 1'b1;
            state      <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          // in_ready is raised here so the first LOAD cycle can accept.
          state        <= LOAD;
          bus.in_ready <= 1'b1;
          bus.busy     <= 1'b0;
        end

        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mema_loader.sv
// tb/tb_mema_loader.sv - directed self-checking bench for mema_loader (DIM=4, BITS_AB=8)
module tb_mema_loader;

  localparam int DIM = 4;
  localparam int BW  = 8;
  localparam int SL  = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   epoch = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mema_loader_if #(.BITS_AB(BW), .DIM(DIM)) bus ();

  mema_loader #(.BITS_AB(BW), .DIM(DIM), .STREAM_LEN(SL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Event log, cleared whenever the stimulus bumps epoch.
  logic [31:0] wr_word [$];
  int          wr_arow [$];
  int          wr_cyc  [$];
  int          acc_cyc [$];
  int          en_cnt, en_first, en_last, overlap, done_cyc;
  int          log_epoch = 0;

  always @(negedge clk) begin
    logic [31:0] w;
    if (log_epoch != epoch) begin
      wr_word.delete(); wr_arow.delete(); wr_cyc.delete(); acc_cyc.delete();
      en_cnt = 0; en_first = -1; en_last = -1; overlap = 0; done_cyc = -1;
      log_epoch = epoch;
    end
    if (bus.mem_wren) begin
      for (int c = 0; c < DIM; c++) w[8*c +: 8] = bus.mem_ain[c];
      wr_word.push_back(w);
      wr_arow.push_back(int'(bus.mem_arow));
      wr_cyc.push_back(cyc);
    end
    if (bus.mem_en) begin
      if (en_cnt == 0) en_first = cyc;
      en_last = cyc;
      en_cnt++;
    end
    if (bus.mem_wren && bus.mem_en) overlap++;
    if (bus.done) done_cyc = cyc;
    if (bus.in_valid && bus.in_ready) acc_cyc.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int v, input bit last, input int gap);
    int n;
    bus.in_data  = 8'(v);
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 100);
    if (!bus.in_ready) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, 64'(seen), 1);
  endtask

  task automatic check_rows(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                            input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] exp [4];
    exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
    chk({tag, "_wr_count"}, 64'(wr_word.size()), 4);
    for (int i = 0; i < 4; i++) begin
      if (wr_word.size() > i) begin
        chk($sformatf("%s_arow%0d", tag, i), 64'(wr_arow[i]), 64'(i));
        chk($sformatf("%s_word%0d", tag, i), 64'(wr_word[i]), 64'(exp[i]));
      end
    end
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_en_len"}, 64'(en_cnt), SL);
    chk({tag, "_en_contig"}, 64'(en_last - en_first + 1), SL);
    chk({tag, "_en_after_wr"}, 64'(en_first), 64'(wr_cyc[3] + 1));
    chk({tag, "_done_after_en"}, 64'(done_cyc), 64'(en_last + 1));
    chk({tag, "_no_overlap"}, 64'(overlap), 0);
    chk({tag, "_ready_after"}, 64'(bus.in_ready), 1);
    chk({tag, "_idle_after"}, 64'(bus.busy), 0);
  endtask

  initial begin
    logic [31:0] w0;
    bit          last6;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < DIM; c++) w0[8*c +: 8] = bus.mem_ain[c];
    chk("rst_ready", 64'(bus.in_ready), 0);
    chk("rst_wren", 64'(bus.mem_wren), 0);
    chk("rst_en", 64'(bus.mem_en), 0);
    chk("rst_busy", 64'(bus.busy), 0);
    chk("rst_done", 64'(bus.done), 0);
    chk("rst_arow", 64'(bus.mem_arow), 0);
    chk("rst_ain", 64'(w0), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    epoch++;
    @(posedge clk); #1;
    chk("post_rst_ready", 64'(bus.in_ready), 1);
    chk("post_rst_busy", 64'(bus.busy), 0);
    chk("post_rst_wren", 64'(bus.mem_wren), 0);
    chk("post_rst_en", 64'(bus.mem_en), 0);

    // Full matrix, back-to-back
    for (int v = 1; v <= 16; v++) send(v, 1'b0, 0);
    chk("b2b_busy", 64'(bus.busy), 1);
    wait_done("b2b");
    @(posedge clk); #1;
    chk("b2b_acc_count", 64'(acc_cyc.size()), 16);
    check_rows("b2b", 32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D);
    for (int i = 0; i < 4; i++)
      chk($sformatf("b2b_wr_lat%0d", i), 64'(wr_cyc[i]), 64'(acc_cyc[4*i+3] + 1));
    check_stream("b2b");

    // Same data, in_valid every other cycle (in_last on element 6 must be ignored unless partial rows are enabled)
`ifdef LOADER_PARTIAL_ROW_EN
    last6 = 1'b0;
`else
    last6 = 1'b1;
`endif
    epoch++;
    @(posedge clk); #1;
    for (int v = 1; v <= 16; v++) send(v, (v == 6) ? last6 : 1'b0, 1);
    wait_done("gap");
    @(posedge clk); #1;
    check_rows("gap", 32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D);
    chk("gap_wr_spacing", 64'(wr_cyc[1] - wr_cyc[0]), 8);
    chk("gap_wr_lat", 64'(wr_cyc[3]), 64'(acc_cyc[15] + 1));
    check_stream("gap");

    // Reset after 6 elements, then a fresh matrix 101..116
    for (int v = 1; v <= 6; v++) send(v, 1'b0, 0);
    rst = 1'b1;
    epoch++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_write", 64'(wr_word.size()), 0);
    for (int v = 101; v <= 116; v++) send(v, 1'b0, 0);
    wait_done("abort");
    @(posedge clk); #1;
    check_rows("abort", 32'h68676665, 32'h6C6B6A69, 32'h706F6E6D, 32'h74737271);
    check_stream("abort");

    // in_valid held with 200 through STREAM/DONE
    epoch++;
    @(posedge clk); #1;
    for (int v = 1; v <= 16; v++) send(v, 1'b0, 0);
    bus.in_data  = 8'd200;
    bus.in_valid = 1'b1;
    wait_done("hold");
    chk("hold_ready_in_done", 64'(bus.in_ready), 0);
    chk("hold_no_accept", 64'(acc_cyc.size()), 16);
    @(negedge clk);
    chk("hold_ready_load", 64'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("hold_accepted", 64'(acc_cyc.size()), 17);
    chk("hold_busy", 64'(bus.busy), 1);
    epoch++;
    @(posedge clk); #1;
    for (int v = 201; v <= 203; v++) send(v, 1'b0, 0);
    for (int n = 0; n < 20 && wr_word.size() == 0; n++) begin
      @(posedge clk); #1;
    end
    chk("hold_row0_count", 64'(wr_word.size()), 1);
    chk("hold_row0_arow", 64'(wr_arow[0]), 0);
    chk("hold_row0_word", 64'(wr_word[0]), 64'h00000000CBCAC9C8);

`ifdef LOADER_PARTIAL_ROW_EN
    // Early end of matrix after 6 elements
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    epoch++;
    @(posedge clk); #1;
    for (int v = 1; v <= 6; v++) send(v, v == 6, 0);
    chk("part_ready_drop", 64'(bus.in_ready), 0);
    wait_done("part");
    @(posedge clk); #1;
    check_rows("part", 32'h04030201, 32'h00000605, 32'h00000000, 32'h00000000);
    chk("part_wr1_lat", 64'(wr_cyc[1]), 64'(acc_cyc[5] + 1));
    chk("part_wr2_consec", 64'(wr_cyc[2]), 64'(wr_cyc[1] + 1));
    chk("part_wr3_consec", 64'(wr_cyc[3]), 64'(wr_cyc[1] + 2));
    chk("part_acc_count", 64'(acc_cyc.size()), 6);
    check_stream("part");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
